ram_responder: RTL

Memory-side responder for the CPU's asynchronous-style memory handshake (MOV/RW/MOC). It accepts an address, a write word and an access size from the datapath's MAR/MDR, performs a big-endian byte/halfword/word read or write on an internal byte array after a programmable latency, and raises MOC to complete the transfer. One instance serves instruction fetch (MOC), a second serves data accesses (DMOC).

---
 rtl/ram_pkg.sv | 50 +++++
 rtl/ram_byte_array.sv | 38 +++
 rtl/ram_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared encodings for the memory responder.
//   size_e    - access size codes carried on the Size port
//   state_e   - responder handshake states
//   RW_READ / RW_WRITE - polarity of the RW port
//   access_bad()  - alignment / reserved-size rejection rule
//   lane_mask()   - which big-endian byte lanes an access touches
// Lane numbering: lane 0 is the byte at the lowest address of a word and
// sits in bits 31:24; lane 3 is bits 7:0.
package ram_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Misaligned halfword/word or the reserved size code is rejected.
   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Bit k of the result enables lane k.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << addr_lo;
         SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: byte storage organised as four byte-wide banks, one per
// big-endian lane, so any aligned byte/halfword/word is a single-word access.
// Ports:
//   clk   - clock
//   re    - read enable; rdata updates only on an edge with re=1
//   addr  - word index
//   we    - per-lane write enable (bit k -> lane k, bits 31-8k .. 24-8k)
//   wdata - write word, lane k taken from bits 31-8k .. 24-8k
//   rdata - registered read word, lane 0 in bits 31:24
module ram_byte_array #(
   parameter int DEPTH_BYTES = 512,
   localparam int WAW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES / 4) : 1
) (
   input  logic            clk,
   input  logic            re,
   input  logic [WAW-1:0]  addr,
   input  logic [3:0]      we,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] bank [2**WAW];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (we[gi]) begin
            bank[addr] <= wdata[31-8*gi -: 8];
         end
         if (re) begin
            rd_q <= bank[addr];
         end
      end

      assign rdata[31-8*gi -: 8] = rd_q;
   end

endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory side of the MOV/RW/MOC handshake. Captures a
// request, waits LATENCY edges, performs a big-endian byte/half/word access
// on the internal array and holds MOC until the CPU drops MOV.
// Ports:
//   clk     - clock
//   reset   - synchronous, active-low reset
//   MOV     - request valid, held by CPU until MOC
//   RW      - 1 read, 0 write
//   Address - byte address (wraps modulo DEPTH_BYTES)
//   DataIn  - right-justified write data
//   Size    - 00 byte, 01 half, 10 word, 11 reserved
//   DataOut - right-justified, zero-extended read data (0 for writes/errors)
//   MOC     - transfer complete
//   ERR     - request rejected; meaningful while MOC=1
module ram_responder
   import ram_pkg::*;
#(
   parameter int DEPTH_BYTES = 512,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MOV,
   input  logic        RW,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   input  logic [1:0]  Size,
   output logic [31:0] DataOut,
   output logic        MOC,
   output logic        ERR
);

   localparam int AW  = $clog2(DEPTH_BYTES);
   localparam int WAW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES / 4) : 1;
   localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   // Captured request
   logic [AW-1:0]  addr_q;
   logic [31:0]    wdata_q;
   logic           rw_q;
   logic [1:0]     size_q;

   // Result of the last completed access; DataOut is decoded from these
   // because the array read data only appears after the access edge.
   logic           res_rd_q;
   logic [1:0]     res_size_q;
   logic [1:0]     res_off_q;
   logic           err_q;

   logic           unused_addr_hi;
   assign unused_addr_hi = ^Address[31:AW];

   // In IDLE the live inputs are the request (needed when LATENCY=1 performs
   // the access on the capture edge); afterwards the captured copy is used.
   logic           in_idle;
   logic [AW-1:0]  req_addr;
   logic [31:0]    req_wdata;
   logic           req_rw;
   logic [1:0]     req_size;
   logic           req_bad;
   logic           accept;
   logic           access;

   assign in_idle   = (state_q == ST_IDLE);
   assign req_addr  = in_idle ? Address[AW-1:0] : addr_q;
   assign req_wdata = in_idle ? DataIn : wdata_q;
   assign req_rw    = in_idle ? RW : rw_q;
   assign req_size  = in_idle ? Size : size_q;
   assign req_bad   = access_bad(req_size, req_addr[1:0]);

   assign accept = in_idle && MOV;
   // Reset outranks everything, so an access edge under reset never writes.
   assign access = reset &&
                   ((accept && (LATENCY == 1)) ||
                    ((state_q == ST_BUSY) && MOV && (cnt_q == '0)));

   logic [3:0]     mem_we;
   logic           mem_re;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;

   assign mem_we = (access && (req_rw == RW_WRITE) && !req_bad)
                   ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
   assign mem_re = access && (req_rw == RW_READ) && !req_bad;

   // Replicate the low bytes so the selected lanes pick up the right data.
   always_comb begin
      case (req_size)
         SZ_BYTE: mem_wdata = {4{req_wdata[7:0]}};
         SZ_HALF: mem_wdata = {2{req_wdata[15:0]}};
         default: mem_wdata = req_wdata;
      endcase
   end

   ram_byte_array #(
      .DEPTH_BYTES(DEPTH_BYTES)
   ) u_array (
      .clk   (clk),
      .re    (mem_re),
      .addr  (WAW'(req_addr >> 2)),
      .we    (mem_we),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (MOV) begin
               if (LATENCY == 1) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CW'(LATENCY - 1);
               end
            end
         end
         ST_BUSY: begin
            if (!MOV) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (!MOV) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      MOC = (state_q == ST_DONE);
   end

   // Capture and result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         rw_q       <= RW_READ;
         size_q     <= SZ_BYTE;
         res_rd_q   <= 1'b0;
         res_size_q <= SZ_BYTE;
         res_off_q  <= 2'b00;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= Address[AW-1:0];
            wdata_q <= DataIn;
            rw_q    <= RW;
            size_q  <= Size;
         end
         if (access) begin
            err_q      <= req_bad;
            res_rd_q   <= (req_rw == RW_READ) && !req_bad;
            res_size_q <= req_size;
            res_off_q  <= req_addr[1:0];
         end
      end
   end

   // Right-justify the addressed lanes of the read word.
   always_comb begin
      DataOut = 32'h0;
      if (res_rd_q) begin
         case (res_size_q)
            SZ_BYTE: begin
               case (res_off_q)
                  2'd0:    DataOut = {24'h0, mem_rdata[31:24]};
                  2'd1:    DataOut = {24'h0, mem_rdata[23:16]};
                  2'd2:    DataOut = {24'h0, mem_rdata[15:8]};
                  default: DataOut = {24'h0, mem_rdata[7:0]};
               endcase
            end
            SZ_HALF: DataOut = res_off_q[1] ? {16'h0, mem_rdata[15:0]}
                                            : {16'h0, mem_rdata[31:16]};
            default: DataOut = mem_rdata;
         endcase
      end
   end

   assign ERR = err_q;

endmodule
